// File: rtl/alu_execute_stage.sv
// Two-stage pipelined integer ALU sitting between the ALU control decoder and
// writeback/branch logic. Stage 1 captures the operation, stage 2 registers the
// result and flags. Valid/ready on both sides with full backpressure.
module alu_execute_stage #(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset_N,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [3:0]       Control,
   input  logic [WIDTH-1:0] Operand_A,
   input  logic [WIDTH-1:0] Operand_B,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow,
   output logic             Illegal
);

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_AND = 4'b0011;
   localparam logic [3:0] OP_OR  = 4'b0100;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;

   // stage 1 capture register
   logic             s1_valid;
   logic [3:0]       s1_ctrl;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   // stage 2 output register
   logic             s2_valid;
   logic [WIDTH-1:0] s2_result;
   logic             s2_zero;
   logic             s2_ovf;
   logic             s2_ill;

   // handshake terms
   logic s2_free;
   logic s1_adv;
   logic accept;

   assign s2_free  = !s2_valid || Out_Ready;
   assign s1_adv   = s1_valid && s2_free;
   assign In_Ready = !s1_valid || s2_free;
   assign accept   = In_Valid && In_Ready;

   // datapath on the stage 1 contents
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_ill;
   logic             alu_zero;

   assign sum  = s1_a + s1_b;
   assign diff = s1_a - s1_b;

   // operation select; unsupported codes yield zero and flag Illegal
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (s1_ctrl)
         OP_NOP: ;
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_AND: alu_res = s1_a & s1_b;
         OP_OR:  alu_res = s1_a | s1_b;
         OP_XOR: alu_res = s1_a ^ s1_b;
         OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
         default: alu_ill = 1'b1;
      endcase
   end

   // Zero follows the final result, so NOP and illegal codes report Zero=1
   assign alu_zero = (alu_res == '0);

   // stage 1: load on accept, empty when it advances without a refill
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         s1_valid <= 1'b0;
         s1_ctrl  <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_ctrl  <= Control;
         s1_a     <= Operand_A;
         s1_b     <= Operand_B;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // stage 2: load on advance, drop valid when drained with nothing behind it;
   // contents hold while stalled
   always_ff @(posedge Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_zero   <= 1'b0;
         s2_ovf    <= 1'b0;
         s2_ill    <= 1'b0;
      end else if (s1_adv) begin
         s2_valid  <= 1'b1;
         s2_result <= alu_res;
         s2_zero   <= alu_zero;
         s2_ovf    <= alu_ovf;
         s2_ill    <= alu_ill;
      end else if (s2_valid && Out_Ready) begin
         s2_valid  <= 1'b0;
      end
   end

   assign Out_Valid = s2_valid;
   assign Result    = s2_result;
   assign Zero      = s2_zero;
   assign Overflow  = s2_ovf;
   assign Illegal   = s2_ill;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed bench for alu_execute_stage: table of vectors with hand-computed
// results, scoreboard for ordering/latency, plus backpressure and reset sequences.
module tb_alu_execute_stage;

   logic        Clock;
   logic        Reset_N;
   logic        In_Valid;
   logic        In_Ready;
   logic [3:0]  Control;
   logic [31:0] Operand_A;
   logic [31:0] Operand_B;
   logic        Out_Valid;
   logic        Out_Ready;
   logic [31:0] Result;
   logic        Zero;
   logic        Overflow;
   logic        Illegal;

   alu_execute_stage #(.WIDTH(32)) dut (
      .Clock     (Clock),
      .Reset_N   (Reset_N),
      .In_Valid  (In_Valid),
      .In_Ready  (In_Ready),
      .Control   (Control),
      .Operand_A (Operand_A),
      .Operand_B (Operand_B),
      .Out_Valid (Out_Valid),
      .Out_Ready (Out_Ready),
      .Result    (Result),
      .Zero      (Zero),
      .Overflow  (Overflow),
      .Illegal   (Illegal)
   );

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        o;
      logic        il;
   } vec_t;

   vec_t vecs [16];
   vec_t idle;
   vec_t sb_q [$];
   int   lat_q [$];
   int   checks;
   int   errors;
   int   cyc;
   int   n_acc;
   int   n_del;
   bit   lat_on;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // apply inputs for one cycle, score any handshakes, return at next negedge
   task automatic drive(input logic v, input vec_t x, input logic ordy);
      vec_t e;
      int   t;
      In_Valid  = v;
      Control   = x.ctrl;
      Operand_A = x.a;
      Operand_B = x.b;
      Out_Ready = ordy;
      #1;
      if (Out_Valid && Out_Ready) begin
         n_del++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h required=none", Result);
         end else begin
            e = sb_q.pop_front();
            t = lat_q.pop_front();
            chk("result", Result, e.res);
            chk("zero", {31'd0, Zero}, {31'd0, e.z});
            chk("overflow", {31'd0, Overflow}, {31'd0, e.o});
            chk("illegal", {31'd0, Illegal}, {31'd0, e.il});
            if (lat_on) chk("latency", 32'(cyc - t), 32'd2);
         end
      end
      if (In_Valid && In_Ready) begin
         sb_q.push_back(x);
         lat_q.push_back(cyc);
         n_acc++;
      end
      cyc++;
      @(negedge Clock);
   endtask

   task automatic drain(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         if (sb_q.size() == 0) break;
         drive(1'b0, idle, 1'b1);
      end
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      int acc0;
      int del0;
      int bi;
      checks = 0; errors = 0; cyc = 0; n_acc = 0; n_del = 0; lat_on = 1'b1;
      idle = '0;
      //            ctrl   A             B             result        z     o     il
      vecs[0]  = '{4'h2, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'h6, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{4'h3, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{4'h5, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{4'h2, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{4'h6, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{4'h7, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
      vecs[8]  = '{4'hF, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b1};
      vecs[9]  = '{4'h9, 32'd1,        32'd2,        32'd0,        1'b1, 1'b0, 1'b1};
      vecs[10] = '{4'h0, 32'd3,        32'd4,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[11] = '{4'h7, 32'd5,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b0};
      vecs[12] = '{4'h2, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[13] = '{4'h6, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{4'h6, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 1'b0};
      vecs[15] = '{4'h2, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b1, 1'b0};

      // reset held with a valid request on the input
      Reset_N = 1'b1; In_Valid = 1'b1; Out_Ready = 1'b1;
      Control = vecs[0].ctrl; Operand_A = vecs[0].a; Operand_B = vecs[0].b;
      #1 Reset_N = 1'b0;
      repeat (3) @(negedge Clock);
      chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
      chk("rst_result", Result, 32'd0);
      chk("rst_flags", {29'd0, Zero, Overflow, Illegal}, 32'd0);
      Reset_N = 1'b1;
      #1 chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);

      // back-to-back stream, no backpressure: every vector accepted each cycle
      acc0 = n_acc;
      for (int i = 0; i < 16; i++) drive(1'b1, vecs[i], 1'b1);
      chk("stream_accepts", 32'(n_acc - acc0), 32'd16);
      drain(10);

      // backpressure: 3 ops offered while the output is stalled for 4 cycles
      lat_on = 1'b0;
      acc0 = n_acc; del0 = n_del; bi = 0;
      for (int c = 0; c < 4; c++) begin
         if (c >= 2) begin
            chk("bp_hold_valid", {31'd0, Out_Valid}, 32'd1);
            chk("bp_hold_result", Result, vecs[0].res);
         end
         drive(1'b1, vecs[bi], 1'b0);
         if (n_acc - acc0 > bi) bi++;
      end
      chk("bp_accepted", 32'(n_acc - acc0), 32'd2);
      #1 chk("bp_in_ready", {31'd0, In_Ready}, 32'd0);
      chk("bp_result_stable", Result, vecs[0].res);
      @(negedge Clock);
      for (int c = 0; c < 12; c++) begin
         if (bi >= 3 && sb_q.size() == 0) break;
         if (bi < 3) begin
            drive(1'b1, vecs[bi], 1'b1);
            if (n_acc - acc0 > bi) bi++;
         end else begin
            drive(1'b0, idle, 1'b1);
         end
      end
      chk("bp_delivered", 32'(n_del - del0), 32'd3);
      chk("bp_empty", 32'(sb_q.size()), 32'd0);

      // mid-flight reset with both stages full
      drive(1'b1, vecs[3], 1'b0);
      drive(1'b1, vecs[4], 1'b0);
      chk("mid_full", {31'd0, Out_Valid}, 32'd1);
      #2 Reset_N = 1'b0;
      #1 chk("mid_async_valid", {31'd0, Out_Valid}, 32'd0);
      chk("mid_async_result", Result, 32'd0);
      sb_q.delete();
      lat_q.delete();
      In_Valid = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset_N = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drive(1'b0, idle, 1'b1);
         chk("mid_no_stale", {31'd0, Out_Valid}, 32'd0);
      end
      lat_on = 1'b1;
      drive(1'b1, vecs[8], 1'b1);
      drain(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
